// File: rtl/spi_master_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_master_pkg : shared types for the SPI master engine
// Rev 1.0
// ---------------------------------------------------------------------------
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_XFER     = 3'd2,
        ST_TEARDOWN = 3'd3,
        ST_HOLD     = 3'd4,
        ST_GAP      = 3'd5
    } state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

    // Width-independent part of a command; widths of data/len/div/cs live in the top.
    typedef struct packed {
        mode_t mode;
        logic  hold;
    } cmd_flags_t;

    function automatic logic is_sample_edge(input mode_t m, input logic lead);
        return m.cpha ? ~lead : lead;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_clk_gen : half-period counter with edge strobe and leading/trailing flag
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             arm_i,
    input  logic             edge_i,
    output logic             tick_o,
    output logic             lead_o
);

    logic [DIV_W-1:0] cnt_q;
    logic             phase_q;

    assign tick_o = (cnt_q == div_i);
    assign lead_o = phase_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            if (restart_i || tick_o) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            // phase marks whether the next generated sclk edge is the leading one
            if (arm_i) begin
                phase_q <= 1'b1;
            end else if (edge_i) begin
                phase_q <= ~phase_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_master_ctrl : command-driven SPI master, MSB-first, per-command mode/CS/hold
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_master_ctrl
    import spi_master_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8,
    parameter int LEN_W  = $clog2(DATA_W),
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CS_W-1:0]   cmd_cs,
    input  logic [DIV_W-1:0]  cmd_div,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_cpol,
    input  logic              cmd_cpha,
    input  logic              cmd_hold,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [LEN_W:0] FULL_LEN = DATA_W[LEN_W:0];
    localparam logic [CS_W:0]  CS_LIMIT = NUM_CS[CS_W:0];

    state_e            state_q,    state_d;
    logic [CS_W-1:0]   cs_q,       cs_d;
    logic [DIV_W-1:0]  div_q,      div_d;
    logic [LEN_W:0]    len_q,      len_d;
    cmd_flags_t        flags_q,    flags_d;
    logic [DATA_W-1:0] tx_q,       tx_d;
    logic [DATA_W-1:0] rx_q,       rx_d;
    logic [LEN_W+1:0]  edge_q,     edge_d;
    logic              pend_q,     pend_d;
    logic              sclk_q,     sclk_d;
    logic              mosi_q,     mosi_d;
    logic [NUM_CS-1:0] cs_n_q,     cs_n_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q,  rsp_err_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic              accept;
    logic              cs_ok;
    logic [LEN_W:0]    new_len;
    logic [DATA_W-1:0] new_tx;
    cmd_flags_t        new_flags;
    logic [LEN_W+1:0]  total_edges;
    logic              tick;
    logic              lead;
    logic              restart;
    logic              edge_now;
    logic              start_now;
    logic [CS_W-1:0]   start_cs;
    logic [DATA_W-1:0] start_tx;
    cmd_flags_t        start_flags;

    assign cmd_ready   = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign busy        = (state_q != ST_IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign cs_ok       = ({1'b0, cmd_cs} < CS_LIMIT);
    assign new_len     = (cmd_len == '0) ? FULL_LEN : {1'b0, cmd_len};
    // left-align so the first bit to send always sits in the MSB
    assign new_tx      = cmd_data << (FULL_LEN - new_len);
    assign total_edges = {len_q, 1'b0};
    assign restart     = (state_d != state_q);

    always_comb begin
        new_flags           = '0;
        new_flags.mode.cpol = cmd_cpol;
        new_flags.mode.cpha = cmd_cpha;
        new_flags.hold      = cmd_hold;
    end

    spi_clk_gen #(
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .clk_i     (pclk),
        .rst_i     (prst),
        .restart_i (restart),
        .div_i     (div_q),
        .arm_i     (start_now),
        .edge_i    (edge_now),
        .tick_o    (tick),
        .lead_o    (lead)
    );

    always_comb begin
        state_d     = state_q;
        cs_d        = cs_q;
        div_d       = div_q;
        len_d       = len_q;
        flags_d     = flags_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        edge_d      = edge_q;
        pend_d      = pend_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        edge_now    = 1'b0;
        start_now   = 1'b0;
        start_cs    = cs_q;
        start_tx    = tx_q;
        start_flags = flags_q;

        if (accept && cs_ok) begin
            cs_d    = cmd_cs;
            div_d   = cmd_div;
            len_d   = new_len;
            flags_d = new_flags;
            tx_d    = new_tx;
            rx_d    = '0;
            edge_d  = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!cs_ok) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        start_now   = 1'b1;
                        start_cs    = cmd_cs;
                        start_tx    = new_tx;
                        start_flags = new_flags;
                        state_d     = ST_SETUP;
                    end
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    if (!cs_ok) begin
                        cs_n_d      = '1;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        state_d     = ST_IDLE;
                    end else if (cmd_cs == cs_q) begin
                        start_now   = 1'b1;
                        start_cs    = cmd_cs;
                        start_tx    = new_tx;
                        start_flags = new_flags;
                        state_d     = ST_SETUP;
                    end else begin
                        // new target: release current CS, honour the gap, then start
                        cs_n_d  = '1;
                        pend_d  = 1'b1;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    edge_now = 1'b1;
                    state_d  = ST_XFER;
                end
            end
            ST_XFER: begin
                if (tick) begin
                    if (edge_q == total_edges) begin
                        mosi_d  = 1'b0;
                        state_d = ST_TEARDOWN;
                    end else begin
                        edge_now = 1'b1;
                    end
                end
            end
            ST_TEARDOWN: begin
                if (tick) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q;
                    if (flags_q.hold) begin
                        state_d = ST_HOLD;
                    end else begin
                        cs_n_d  = '1;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (pend_q) begin
                        pend_d    = 1'b0;
                        start_now = 1'b1;
                        state_d   = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (edge_now) begin
            sclk_d = ~sclk_q;
            edge_d = edge_q + 1'b1;
            if (is_sample_edge(flags_q.mode, lead)) begin
                rx_d = {rx_q[DATA_W-2:0], miso};
            end else if ((edge_q + 1'b1) != total_edges) begin
                mosi_d = tx_q[DATA_W-1];
                tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end
        end

        if (start_now) begin
            for (int i = 0; i < NUM_CS; i++) begin
                cs_n_d[i] = (start_cs != CS_W'(i));
            end
            sclk_d = start_flags.mode.cpol;
            if (!start_flags.mode.cpha) begin
                mosi_d = start_tx[DATA_W-1];
                tx_d   = {start_tx[DATA_W-2:0], 1'b0};
            end else begin
                mosi_d = 1'b0;
                tx_d   = start_tx;
            end
        end
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q     <= ST_IDLE;
            cs_q        <= '0;
            div_q       <= '0;
            len_q       <= '0;
            flags_q     <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            edge_q      <= '0;
            pend_q      <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= '1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            div_q       <= div_d;
            len_q       <= len_d;
            flags_q     <= flags_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            edge_q      <= edge_d;
            pend_q      <= pend_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl : directed self-checking bench for spi_master_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;

    localparam int DATA_W = 32;
    localparam int NUM_CS = 4;
    localparam int DIV_W  = 8;
    localparam int LEN_W  = 5;
    localparam int CS_W   = 3;

    logic              pclk = 1'b0;
    logic              prst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [CS_W-1:0]   cmd_cs = '0;
    logic [DIV_W-1:0]  cmd_div = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              cmd_cpol = 1'b0;
    logic              cmd_cpha = 1'b0;
    logic              cmd_hold = 1'b0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic [NUM_CS-1:0] cs_n;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic        loop_en  = 1'b1;
    logic        slv_miso = 1'b0;
    logic [15:0] slv_word = 16'hbeef;
    logic [15:0] slv_sh   = '0;
    logic [15:0] slv_rx   = '0;

    int edges_m = 0;
    int rsp_m   = 0;
    int cs3_rise_m = 0;
    int cs_low_m [NUM_CS];
    logic        sclk_p = 1'b0;
    logic [3:0]  cs_p   = 4'hf;

    assign miso = loop_en ? mosi : slv_miso;

    spi_master_ctrl #(
        .DATA_W (DATA_W), .NUM_CS (NUM_CS), .DIV_W (DIV_W), .LEN_W (LEN_W), .CS_W (CS_W)
    ) dut (
        .pclk (pclk), .prst (prst), .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
        .cmd_cs (cmd_cs), .cmd_div (cmd_div), .cmd_len (cmd_len), .cmd_cpol (cmd_cpol),
        .cmd_cpha (cmd_cpha), .cmd_hold (cmd_hold), .cmd_data (cmd_data),
        .sclk (sclk), .mosi (mosi), .miso (miso), .cs_n (cs_n),
        .rsp_valid (rsp_valid), .rsp_data (rsp_data), .rsp_err (rsp_err), .busy (busy)
    );

    initial forever #5 pclk = ~pclk;

    initial for (int i = 0; i < NUM_CS; i++) cs_low_m[i] = 0;

    // bus monitor plus a 16-bit mode-3 slave on cs 2 (drives on falling, captures on rising)
    always @(negedge pclk) begin
        if (cs_p != 4'hf && cs_n != 4'hf && sclk != sclk_p) edges_m++;
        if (rsp_valid) rsp_m++;
        if (!cs_p[3] && cs_n[3]) cs3_rise_m++;
        for (int i = 0; i < NUM_CS; i++) if (!cs_n[i]) cs_low_m[i]++;
        if (cs_p[2] && !cs_n[2]) begin
            slv_sh = slv_word;
            slv_rx = '0;
        end else if (!cs_p[2] && !cs_n[2] && sclk != sclk_p) begin
            if (!sclk) begin
                slv_miso = slv_sh[15];
                slv_sh   = slv_sh << 1;
            end else begin
                slv_rx = {slv_rx[14:0], mosi};
            end
        end
        sclk_p = sclk;
        cs_p   = cs_n;
    end

    task automatic send(input logic [2:0] cs, input logic [7:0] div, input logic [4:0] len,
                        input logic cpol, input logic cpha, input logic hold, input logic [31:0] data);
        int n = 0;
        while (!cmd_ready && n < 300) begin
            @(posedge pclk); #1;
            n++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_cs = cs; cmd_div = div; cmd_len = len; cmd_cpol = cpol;
        cmd_cpha = cpha; cmd_hold = hold; cmd_data = data; cmd_valid = 1'b1;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            if (rsp_valid === 1'b1) begin
                got = 1;
                break;
            end
            @(posedge pclk); #1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1 within %0d cycles", rsp_valid, budget);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(posedge pclk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (cs_n !== 4'hf)        begin n_bad++; $display("FAIL rst_cs_n: got %h required f", cs_n); end
        n_cmp++; if (sclk !== 1'b0)        begin n_bad++; $display("FAIL rst_sclk: got %b required 0", sclk); end
        n_cmp++; if (mosi !== 1'b0)        begin n_bad++; $display("FAIL rst_mosi: got %b required 0", mosi); end
        n_cmp++; if (rsp_valid !== 1'b0)   begin n_bad++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'h0)   begin n_bad++; $display("FAIL rst_rsp_data: got %h required 0", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0)     begin n_bad++; $display("FAIL rst_rsp_err: got %b required 0", rsp_err); end
        n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_cmp++; if (cmd_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_cmd_ready: got %b required 1", cmd_ready); end
    endtask

    task automatic test_loopback_mode0;
        int e0 = edges_m, r0 = rsp_m, c0 = cs_low_m[1];
        int o0 = cs_low_m[0] + cs_low_m[2] + cs_low_m[3];
        int gap;
        loop_en = 1'b1;
        send(3'd1, 8'd5, 5'd0, 1'b0, 1'b0, 1'b0, 32'h17f3ad08);
        n_cmp++; if (cs_n !== 4'b1101) begin n_bad++; $display("FAIL lb_cs_n_setup: got %b required 1101", cs_n); end
        wait_rsp(600);
        n_cmp++; if (rsp_data !== 32'h17f3ad08) begin n_bad++; $display("FAIL lb_rsp_data: got %h required 17f3ad08", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0)  begin n_bad++; $display("FAIL lb_rsp_err: got %b required 0", rsp_err); end
        n_cmp++; if (cs_n !== 4'hf)     begin n_bad++; $display("FAIL lb_cs_rise_with_rsp: got %b required 1111", cs_n); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL lb_gap_ready: got %b required 0", cmd_ready); end
        wait_ready(gap);
        n_cmp++; if (gap !== 6)         begin n_bad++; $display("FAIL lb_gap_len: got %0d required 6", gap); end
        n_cmp++; if (cs_low_m[1] - c0 !== 396) begin n_bad++; $display("FAIL lb_cs_low: got %0d required 396", cs_low_m[1] - c0); end
        n_cmp++; if (cs_low_m[0] + cs_low_m[2] + cs_low_m[3] - o0 !== 0) begin n_bad++; $display("FAIL lb_other_cs: got %0d required 0", cs_low_m[0] + cs_low_m[2] + cs_low_m[3] - o0); end
        n_cmp++; if (edges_m - e0 !== 64) begin n_bad++; $display("FAIL lb_edges: got %0d required 64", edges_m - e0); end
        n_cmp++; if (rsp_m - r0 !== 1)  begin n_bad++; $display("FAIL lb_rsp_count: got %0d required 1", rsp_m - r0); end
    endtask

    task automatic test_mode3_slave;
        int e0 = edges_m, c0 = cs_low_m[2];
        int gap;
        loop_en  = 1'b0;
        slv_word = 16'hbeef;
        send(3'd2, 8'd1, 5'd16, 1'b1, 1'b1, 1'b0, 32'h0000dead);
        n_cmp++; if (sclk !== 1'b1)     begin n_bad++; $display("FAIL m3_sclk_setup: got %b required 1", sclk); end
        n_cmp++; if (cs_n !== 4'b1011)  begin n_bad++; $display("FAIL m3_cs_n: got %b required 1011", cs_n); end
        wait_rsp(300);
        n_cmp++; if (rsp_data !== 32'h0000beef) begin n_bad++; $display("FAIL m3_rsp_data: got %h required 0000beef", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0)  begin n_bad++; $display("FAIL m3_rsp_err: got %b required 0", rsp_err); end
        wait_ready(gap);
        n_cmp++; if (edges_m - e0 !== 32) begin n_bad++; $display("FAIL m3_edges: got %0d required 32", edges_m - e0); end
        n_cmp++; if (slv_rx !== 16'hdead) begin n_bad++; $display("FAIL m3_slave_rx: got %h required dead", slv_rx); end
        n_cmp++; if (sclk !== 1'b1)     begin n_bad++; $display("FAIL m3_sclk_idle: got %b required 1", sclk); end
        n_cmp++; if (cs_low_m[2] - c0 !== 68) begin n_bad++; $display("FAIL m3_cs_low: got %0d required 68", cs_low_m[2] - c0); end
        loop_en = 1'b1;
    endtask

    task automatic test_hold_chain;
        int r0 = rsp_m, q0 = cs3_rise_m, c0 = cs_low_m[3], e0 = edges_m;
        int gap;
        loop_en = 1'b1;
        send(3'd3, 8'd2, 5'd0, 1'b0, 1'b0, 1'b1, 32'h17f3ad08);
        wait_rsp(600);
        n_cmp++; if (rsp_data !== 32'h17f3ad08) begin n_bad++; $display("FAIL hold_rsp1: got %h required 17f3ad08", rsp_data); end
        n_cmp++; if (cs_n !== 4'b0111)  begin n_bad++; $display("FAIL hold_cs_kept: got %b required 0111", cs_n); end
        n_cmp++; if (busy !== 1'b1)     begin n_bad++; $display("FAIL hold_busy: got %b required 1", busy); end
        send(3'd3, 8'd10, 5'd16, 1'b0, 1'b0, 1'b0, 32'h0000dead);
        n_cmp++; if (cs_n !== 4'b0111)  begin n_bad++; $display("FAIL hold_cs_second: got %b required 0111", cs_n); end
        wait_rsp(1000);
        n_cmp++; if (rsp_data !== 32'h0000dead) begin n_bad++; $display("FAIL hold_rsp2: got %h required 0000dead", rsp_data); end
        n_cmp++; if (cs_n !== 4'hf)     begin n_bad++; $display("FAIL hold_cs_final: got %b required 1111", cs_n); end
        wait_ready(gap);
        n_cmp++; if (rsp_m - r0 !== 2)  begin n_bad++; $display("FAIL hold_rsp_count: got %0d required 2", rsp_m - r0); end
        n_cmp++; if (cs3_rise_m - q0 !== 1) begin n_bad++; $display("FAIL hold_cs_rises: got %0d required 1", cs3_rise_m - q0); end
        n_cmp++; if (cs_low_m[3] - c0 !== 573) begin n_bad++; $display("FAIL hold_cs_low: got %0d required 573", cs_low_m[3] - c0); end
        n_cmp++; if (edges_m - e0 !== 96) begin n_bad++; $display("FAIL hold_edges: got %0d required 96", edges_m - e0); end
    endtask

    task automatic test_bad_cs;
        int e0 = edges_m;
        int c0 = cs_low_m[0] + cs_low_m[1] + cs_low_m[2] + cs_low_m[3];
        send(3'd5, 8'd3, 5'd8, 1'b0, 1'b0, 1'b0, 32'h000000ff);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bad_rsp_valid: got %b required 1", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b1)  begin n_bad++; $display("FAIL bad_rsp_err: got %b required 1", rsp_err); end
        n_cmp++; if (rsp_data !== 32'h0) begin n_bad++; $display("FAIL bad_rsp_data: got %h required 0", rsp_data); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL bad_busy: got %b required 0", busy); end
        @(posedge pclk); #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bad_rsp_pulse: got %b required 0", rsp_valid); end
        repeat (4) begin @(posedge pclk); #1; end
        n_cmp++; if (edges_m - e0 !== 0) begin n_bad++; $display("FAIL bad_edges: got %0d required 0", edges_m - e0); end
        n_cmp++; if (cs_low_m[0] + cs_low_m[1] + cs_low_m[2] + cs_low_m[3] - c0 !== 0) begin
            n_bad++; $display("FAIL bad_cs_activity: got %0d required 0", cs_low_m[0] + cs_low_m[1] + cs_low_m[2] + cs_low_m[3] - c0);
        end
    endtask

    task automatic test_reset_mid;
        int e0 = edges_m, r0 = rsp_m, n = 0;
        int gap;
        loop_en = 1'b1;
        send(3'd0, 8'd1, 5'd0, 1'b0, 1'b0, 1'b0, 32'hcafef00d);
        while (edges_m - e0 < 20 && n < 500) begin
            @(posedge pclk); #1;
            n++;
        end
        n_cmp++; if (edges_m - e0 !== 20) begin n_bad++; $display("FAIL rmid_edge_reach: got %0d required 20", edges_m - e0); end
        prst = 1'b1;
        #1;
        n_cmp++; if (cs_n !== 4'hf)     begin n_bad++; $display("FAIL rmid_cs_n: got %b required 1111", cs_n); end
        n_cmp++; if (sclk !== 1'b0)     begin n_bad++; $display("FAIL rmid_sclk: got %b required 0", sclk); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL rmid_busy: got %b required 0", busy); end
        repeat (3) @(posedge pclk);
        #1 prst = 1'b0;
        repeat (3) begin @(posedge pclk); #1; end
        n_cmp++; if (rsp_m - r0 !== 0)  begin n_bad++; $display("FAIL rmid_no_rsp: got %0d required 0", rsp_m - r0); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b required 1", cmd_ready); end
        send(3'd0, 8'd2, 5'd8, 1'b0, 1'b0, 1'b0, 32'h000000a5);
        wait_rsp(200);
        n_cmp++; if (rsp_data !== 32'h000000a5) begin n_bad++; $display("FAIL rmid_next_data: got %h required 000000a5", rsp_data); end
        wait_ready(gap);
    endtask

    task automatic test_min_div;
        int c0 = cs_low_m[0], e0 = edges_m;
        loop_en = 1'b1;
        send(3'd0, 8'd0, 5'd1, 1'b0, 1'b1, 1'b0, 32'h00000001);
        wait_rsp(50);
        n_cmp++; if (rsp_data !== 32'h1) begin n_bad++; $display("FAIL min_rsp_data: got %h required 1", rsp_data); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL min_gap_ready: got %b required 0", cmd_ready); end
        @(posedge pclk); #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL min_ready_after_gap: got %b required 1", cmd_ready); end
        n_cmp++; if (cs_low_m[0] - c0 !== 4) begin n_bad++; $display("FAIL min_cs_low: got %0d required 4", cs_low_m[0] - c0); end
        n_cmp++; if (edges_m - e0 !== 2) begin n_bad++; $display("FAIL min_edges: got %0d required 2", edges_m - e0); end
    endtask

    initial begin
        prst = 1'b1;
        repeat (3) @(posedge pclk);
        #1 prst = 1'b0;
        @(posedge pclk); #1;
        test_reset();
        test_loopback_mode0();
        test_mode3_slave();
        test_hold_chain();
        test_bad_cs();
        test_reset_mid();
        test_min_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Parametrised, synthesizable SPI master engine.
- Replaces fixed 16/32-bit bench-only SPI driving with a command-driven RTL block.
- Sits behind the APB register block: a command (cs index, clock divider, length, CPOL/CPHA, data, hold) is accepted on a valid/ready interface and shifted MSB-first; received bits are returned on a one-cycle response strobe.
- Supports per-command mode, variable length, multiple chip selects, and CS hold across back-to-back commands.

Parameters:
DATA_W, 32, max bits per command (8..32)
NUM_CS, 4, number of chip-select outputs (1..8)
DIV_W, 8, width of clock-divider field
LEN_W, $clog2(DATA_W), width of length field; value 0 means DATA_W bits
CS_W, max(1,$clog2(NUM_CS)), width of cs index

Ports:
pclk  in  1  system clock
prst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  engine can accept command this cycle
cmd_cs  in  CS_W  chip-select index
cmd_div  in  DIV_W  half-period = cmd_div+1 pclk cycles
cmd_len  in  LEN_W  bit count (0 = DATA_W)
cmd_cpol  in  1  sclk idle level
cmd_cpha  in  1  0: sample leading edge, 1: sample trailing edge
cmd_hold  in  1  keep CS asserted after this command
cmd_data  in  DATA_W  tx bits, right-aligned, sent MSB (bit len-1) first
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in (synchronous to sclk, sampled in pclk domain)
cs_n  out  NUM_CS  active-low chip selects
rsp_valid  out  1  one-cycle response strobe
rsp_data  out  DATA_W  received bits, right-aligned, upper bits 0
rsp_err  out  1  qualifies rsp_valid; 1 = cs index out of range
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate): cs_n all 1, sclk 0, mosi 0, rsp_valid 0, rsp_data 0, rsp_err 0, busy 0, state IDLE, cmd_ready 1 after release. Reset mid-transfer aborts it; no response is issued.
- States: IDLE, SETUP, XFER, TEARDOWN, HOLD, GAP.
- Acceptance: handshake = cmd_valid && cmd_ready. cmd_ready = 1 only in IDLE and HOLD. All fields are latched on acceptance; H = cmd_div+1.
- Out-of-range cs (cmd_cs >= NUM_CS): accepted; rsp_valid=1 with rsp_err=1 and rsp_data=0 on the next cycle; no bus activity; state stays or returns to IDLE. If in HOLD, CS is released first.
- Normal flow:
  - Cycle after accept: state SETUP, cs_n[cs]=0, sclk=cpol.
  - CPHA=0: mosi drives the first bit in SETUP.
  - SETUP lasts H cycles, then XFER toggles sclk every H cycles for 2*len edges.
  - CPHA=0: sample miso on odd edges, shift mosi on even edges (except the last).
  - CPHA=1: shift mosi on odd edges, sample on even edges.
  - TEARDOWN lasts H cycles with sclk=cpol.
- Termination, hold=0: cs_n all 1; rsp_valid pulses in the same cycle cs_n rises; then GAP for H cycles (cmd_ready=0, min CS-high time); then IDLE.
- Termination, hold=1: rsp_valid pulses; enter HOLD with CS still low.
  - In HOLD, a same-cs command goes directly to SETUP without deasserting CS.
  - A different-cs command or cmd_valid=0 with the next command hold=0 follows the normal rules: different cs → deassert, GAP, then SETUP with the new cs.
  - HOLD exits only on a new command.
- CS low duration per command (no hold): (2*len+2)*H cycles.
- sclk idle level follows cpol of the latched command; it is 0 after reset.
- Idle or after transfer: mosi returns to 0.
- Simultaneous events: cmd_valid during busy non-HOLD states is not accepted; the command remains pending.

Decomposition:
- Package spi_master_pkg: state enum, mode typedef {cpol, cpha}, command struct.
- Sub-module spi_clk_gen: H-cycle counter producing an edge strobe plus a leading/trailing flag. The counter reloads on state entry.

Test Plan:
- Loopback (miso=mosi), cs=1, div=5, len=0, mode 0, data 0x17f3ad08 → cs_n=4'b1101 for exactly 396 cycles; rsp_data=0x17f3ad08; rsp_err=0.
- cs=2, div=1, len=16, mode 3 (cpol=1, cpha=1), data 0xdead with slave model returning 0xbeef → sclk idles high, 32 edges, rsp_data=0x0000beef.
- Hold chain: cs=3, hold=1, data 0x17f3ad08, then cs=3, len=16, div=10, data 0xdead → cs_n[3] stays low between commands; two rsp_valid pulses; CS rises only after the second.
- cs=5 with NUM_CS=4 → no sclk/cs_n activity; rsp_valid with rsp_err=1 on the cycle after accept.
- Assert prst at edge 20 of a 32-bit transfer → cs_n=4'b1111, sclk=0 immediately; no rsp_valid; next command runs normally.
- div=0, len=1, mode 1 → half-period of 1 cycle; CS low 4 cycles; GAP of 1 cycle before cmd_ready re-asserts.
